apb_reg_completer: RTL
======================

# apb_reg_completer

APB completer (slave) that terminates one of the 16 APB master ports of `apb_bridge_top` and exposes a bank of 32-bit control/status registers to fabric logic. It decodes the 24-bit peripheral-local address, applies byte strobes on writes, and inserts a configurable number of wait states. It flags out-of-range or read-only writes with `apb_pslverr`. It is the standard endpoint for receiver blocks (tracking channels, AGC, correlators) that need MCU-visible registers.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers, 1..64
- `WAIT_STATES`, 1: ACCESS cycles before `apb_pready`, 0..15
- `RO_MASK`, 64'h0: bit i=1 → register i is read-only; reads return `ro_d[i]`
- `sys_clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `apb_paddr`  in  24  byte address; word index = `[23:2]`, `[1:0]` ignored
- `apb_psel`  in  1  select
- `apb_penable`  in  1  access phase
- `apb_pwrite`  in  1  1 = write
- `apb_pstrb`  in  4  byte-lane write strobes
- `apb_pwdata`  in  32  write data
- `apb_prdata`  out  32  read data, valid while `apb_pready`=1
- `apb_pready`  out  1  transfer complete
- `apb_pslverr`  out  1  error, valid only with `apb_pready`
- `reg_q`  out  NUM_REGS×32  current RW register contents
- `ro_d`  in  NUM_REGS×32  status inputs for RO registers
- `wr_pulse`  out  NUM_REGS  one-cycle strobe after a committed write to register i
- `rd_pulse`  out  NUM_REGS  one-cycle strobe after a completed read of register i (for clear-on-read status)

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: when `psel`=1 and `penable`=0, capture index, `pwrite`, `pstrb`, and `pwdata`. Load `wait_cnt`=WAIT_STATES. Enter ACCESS.
- ACCESS: if `psel`=0, abort to IDLE with no commit and `pready`=0. Otherwise, while `wait_cnt`≠0 and `penable`=1, decrement.
- Completion edge: `pready`=1 is sampled with `psel`&`penable`. The write commits per byte lane, `pready` clears, and the FSM returns to IDLE.
- Error when index ≥ NUM_REGS, or on a write to an RO register. The error case sets `pslverr`=1, `prdata`=0, and produces no register change and no `wr_pulse`.
- A write with `pstrb`=0 is legal: no data change, `pslverr`=0, `wr_pulse` still fires.
- Read data: RW register → `reg_q[i]`; RO register → `ro_d[i]` sampled at the edge that raises `pready`.
- Back-to-back transfers: a new SETUP may start in the cycle after completion.

## Timing
- All outputs are registered.
- Reset values: `apb_prdata`=0, `apb_pready`=0, `apb_pslverr`=0, `reg_q`=0, `wr_pulse`=0, `rd_pulse`=0, FSM=IDLE, `wait_cnt`=0.
- SETUP in cycle T0. `pready`, `prdata`, and `pslverr` are high/valid in cycle T1+WAIT_STATES, for exactly one cycle.
- WAIT_STATES=0: `pready`=1 in T1, which is the zero-wait APB case.
- `reg_q` updates at the end of the `pready` cycle. `wr_pulse` and `rd_pulse` are high the following cycle.
- `rst` asserted mid-transfer: the FSM returns to IDLE next edge. No partial write, all registers cleared, no pulse.
- `penable` low during ACCESS with `psel`=1 (protocol violation): hold `wait_cnt` and `pready`, do not commit.

## Structure
- Package `apb_pkg`: `APB_ADDR_W`=24, `APB_DATA_W`=32, `APB_STRB_W`=4, and the `apb_state_e` enum {IDLE, ACCESS}.
- One sub-module, `apb_reg_bank`: NUM_REGS×32 storage with per-lane strobe write, RO masking, and read mux.
- The FSM, wait counter, and decode live in the top module.

## Test plan
- Write 0x00000008/0xDEADBEEF, pstrb=0xF, then read 0x00000008 → `prdata`=0xDEADBEEF, `pslverr`=0, `reg_q[2]`=0xDEADBEEF, `wr_pulse[2]` pulses once.
- WAIT_STATES=3: `pready` rises exactly 4 cycles after SETUP, and is high for 1 cycle. With WAIT_STATES=0, `pready` is high in T1.
- Write 0x11223344 to reg 0 with pstrb=0x5 over an initial 0xAABBCCDD → `reg_q[0]`=0xAA22CC44.
- Read address 0x000040 with NUM_REGS=16 → `pslverr`=1, `prdata`=0. Write to RO reg 3 with `ro_d[3]`=0x5A5A0001 → `pslverr`=1, and a read returns 0x5A5A0001 with `rd_pulse[3]` high.
- Drop `psel` during the second wait cycle of a write → no `reg_q` change, `pready` never asserts. Assert `rst` mid-ACCESS → all outputs 0 next cycle.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB bus widths, the completer FSM state type and a byte-lane merge
// helper used by the register bank.
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 24;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;

    // Word index taken from paddr[23:2]; the bank never holds more than 64 words.
    localparam int unsigned APB_IDX_W  = APB_ADDR_W - 2;
    localparam int unsigned REG_IDX_W  = 6;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [APB_DATA_W-1:0] strb_merge(
        input logic [APB_DATA_W-1:0] old_val,
        input logic [APB_DATA_W-1:0] new_val,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// -----------------------------------------------------------------------------
// apb_reg_bank
// NUM_REGS x 32-bit register storage with per-lane strobed writes. Registers
// flagged in RO_MASK ignore writes and read back their ro_d status input.
//
// Ports:
//   sys_clk, rst  clock, synchronous active-high reset
//   wr_en         commit wr_data into register idx (masked by wr_strb)
//   idx           register index for both the write and the read mux
//   wr_strb       byte-lane write strobes
//   wr_data       write data
//   ro_d          status inputs shown in place of RO registers
//   reg_q         current register contents
//   rd_data       combinational read mux output for idx
// -----------------------------------------------------------------------------
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [63:0] RO_MASK  = 64'h0
) (
    input  logic                                 sys_clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [REG_IDX_W-1:0]                 idx,
    input  logic [APB_STRB_W-1:0]                wr_strb,
    input  logic [APB_DATA_W-1:0]                wr_data,
    input  logic [NUM_REGS-1:0][APB_DATA_W-1:0]  ro_d,
    output logic [NUM_REGS-1:0][APB_DATA_W-1:0]  reg_q,
    output logic [APB_DATA_W-1:0]                rd_data
);

    logic [NUM_REGS-1:0][APB_DATA_W-1:0] reg_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        reg_d   = reg_q;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == REG_IDX_W'(i)) begin
                rd_data = RO_MASK[i] ? ro_d[i] : reg_q[i];
                if (wr_en && !RO_MASK[i]) begin
                    reg_d[i] = strb_merge(reg_q[i], wr_data, wr_strb);
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: this storage is software-visible control state, so it is reset
        // like any other flop; a large RAM-style array would normally not be.
        if (rst) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

endmodule

// File: rtl/apb_reg_completer.sv
// -----------------------------------------------------------------------------
// apb_reg_completer
// APB completer exposing a bank of 32-bit control/status registers. Decodes
// the word index from paddr[23:2], inserts WAIT_STATES access cycles before
// pready, and flags out-of-range accesses or writes to RO registers with
// pslverr. All outputs are registered.
//
// Ports:
//   sys_clk, rst                 clock, synchronous active-high reset
//   apb_paddr/psel/penable/      APB request
//   pwrite/pstrb/pwdata
//   apb_prdata/pready/pslverr    APB response (valid for one cycle)
//   reg_q                        RW register contents to fabric
//   ro_d                         status inputs for RO registers
//   wr_pulse / rd_pulse          one-cycle strobe after a committed write /
//                                completed read of register i
// -----------------------------------------------------------------------------
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [63:0] RO_MASK     = 64'h0
) (
    input  logic                                 sys_clk,
    input  logic                                 rst,
    input  logic [APB_ADDR_W-1:0]                apb_paddr,
    input  logic                                 apb_psel,
    input  logic                                 apb_penable,
    input  logic                                 apb_pwrite,
    input  logic [APB_STRB_W-1:0]                apb_pstrb,
    input  logic [APB_DATA_W-1:0]                apb_pwdata,
    output logic [APB_DATA_W-1:0]                apb_prdata,
    output logic                                 apb_pready,
    output logic                                 apb_pslverr,
    output logic [NUM_REGS-1:0][APB_DATA_W-1:0]  reg_q,
    input  logic [NUM_REGS-1:0][APB_DATA_W-1:0]  ro_d,
    output logic [NUM_REGS-1:0]                  wr_pulse,
    output logic [NUM_REGS-1:0]                  rd_pulse
);

    localparam logic [APB_IDX_W-1:0] NUM_REGS_IDX = APB_IDX_W'(NUM_REGS);

    apb_state_e                state_q, state_d;
    logic [APB_IDX_W-1:0]      idx_q, idx_d;
    logic                      write_q, write_d;
    logic [APB_STRB_W-1:0]     strb_q, strb_d;
    logic [APB_DATA_W-1:0]     wdata_q, wdata_d;
    logic [3:0]                wait_cnt_q, wait_cnt_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [APB_DATA_W-1:0]     prdata_q, prdata_d;
    logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-1:0]       rd_pulse_q, rd_pulse_d;

    logic                      unused_addr_lsbs;
    assign unused_addr_lsbs = ^apb_paddr[1:0];

    // With zero wait states the response is raised on the SETUP edge itself,
    // so decode looks at the live bus in IDLE and at the captured request after.
    logic [APB_IDX_W-1:0]      acc_idx;
    logic                      acc_write;
    logic                      acc_err;
    logic                      bank_wr_en;
    logic [APB_DATA_W-1:0]     bank_rd_data;
    logic                      raise_ready;

    assign acc_idx   = (state_q == IDLE) ? apb_paddr[APB_ADDR_W-1:2] : idx_q;
    assign acc_write = (state_q == IDLE) ? apb_pwrite : write_q;
    assign acc_err   = (acc_idx >= NUM_REGS_IDX)
                     || (acc_write && RO_MASK[acc_idx[REG_IDX_W-1:0]]);

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_bank (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .wr_en    (bank_wr_en),
        .idx      (acc_idx[REG_IDX_W-1:0]),
        .wr_strb  (strb_q),
        .wr_data  (wdata_q),
        .ro_d     (ro_d),
        .reg_q    (reg_q),
        .rd_data  (bank_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        write_d     = write_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        pready_d    = pready_q;
        pslverr_d   = pslverr_q;
        prdata_d    = prdata_q;
        wr_pulse_d  = '0;
        rd_pulse_d  = '0;
        bank_wr_en  = 1'b0;
        raise_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (apb_psel && !apb_penable) begin
                    idx_d       = apb_paddr[APB_ADDR_W-1:2];
                    write_d     = apb_pwrite;
                    strb_d      = apb_pstrb;
                    wdata_d     = apb_pwdata;
                    wait_cnt_d  = 4'(WAIT_STATES);
                    state_d     = ACCESS;
                    raise_ready = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!apb_psel) begin
                    // Master abandoned the transfer: nothing commits.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                    pready_d   = 1'b0;
                    pslverr_d  = 1'b0;
                    prdata_d   = '0;
                end else if (apb_penable) begin
                    if (pready_q) begin
                        // Completion edge: the master has seen pready.
                        bank_wr_en = write_q && !acc_err;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (idx_q == APB_IDX_W'(i) && !acc_err) begin
                                wr_pulse_d[i] = write_q;
                                rd_pulse_d[i] = !write_q;
                            end
                        end
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                    end else if (wait_cnt_q != '0) begin
                        wait_cnt_d  = wait_cnt_q - 4'd1;
                        raise_ready = (wait_cnt_q == 4'd1);
                    end
                end
                // penable low with psel high: hold everything, commit nothing.
            end
            default: state_d = IDLE;
        endcase

        if (raise_ready) begin
            pready_d  = 1'b1;
            pslverr_d = acc_err;
            prdata_d  = (acc_err || acc_write) ? '0 : bank_rd_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            write_q    <= 1'b0;
            strb_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign apb_prdata  = prdata_q;
    assign apb_pready  = pready_q;
    assign apb_pslverr = pslverr_q;
    assign wr_pulse    = wr_pulse_q;
    assign rd_pulse    = rd_pulse_q;

endmodule
